// File: rtl/cpu_int_pkg.sv
// cpu_int_pkg
//   Shared definitions for the CPU interrupt path. The interrupt controller and
//   the CPU control unit both use them.
//   - FSM state encoding of int_controller (IDLE / REQ / SERVICE)
//   - width of the interrupt id
//   - default vector base and stride used by the CPU control unit
//   - vec_addr(): base + id * stride, wrapped to the 10-bit address space
package cpu_int_pkg;

   localparam int INT_ID_W = 3;
   localparam int VEC_W    = 10;

   typedef logic [1:0] int_state_t;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   localparam logic [VEC_W-1:0] VEC_BASE_DEF   = 10'h3C0;
   localparam logic [VEC_W-1:0] VEC_STRIDE_DEF = 10'd16;

   // The arithmetic is done at VEC_W bits, so any overflow wraps modulo 2^10.
   function automatic logic [VEC_W-1:0] vec_addr(input logic [VEC_W-1:0]    base,
                                                 input logic [VEC_W-1:0]    stride,
                                                 input logic [INT_ID_W-1:0] id);
      logic [VEC_W-1:0] id_ext;
      id_ext = {{(VEC_W-INT_ID_W){1'b0}}, id};
      return base + id_ext * stride;
   endfunction

endpackage

// File: rtl/int_edge_latch.sv
// int_edge_latch
//   Edge detector and request latch for one interrupt source.
//   Ports:
//     clk, reset  system clock, synchronous active-high reset
//     irq_i       request line, synchronous to clk; a rising edge is a request
//     clr_i       clear pending (the controller has taken this source)
//     pend_o      request latched and not yet taken
//     ovf_o       sticky: an edge arrived while this source was already pending
module int_edge_latch (
   input  logic clk,
   input  logic reset,
   input  logic irq_i,
   input  logic clr_i,
   output logic pend_o,
   output logic ovf_o
);

   logic prev_q, prev_d;
   logic pend_q, pend_d;
   logic ovf_q,  ovf_d;
   logic edge_w;

   assign edge_w = irq_i & ~prev_q;

   always_comb begin
      prev_d = irq_i;
      // A new edge beats a clear in the same cycle, so a request is never lost.
      pend_d = edge_w | (pend_q & ~clr_i);
      // An edge in the clear cycle re-arms the source and is not an overflow.
      ovf_d  = ovf_q | (edge_w & pend_q & ~clr_i);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b0;
         pend_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         prev_q <= prev_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   assign pend_o = pend_q;
   assign ovf_o  = ovf_q;

endmodule

// File: rtl/int_controller.sv
// int_controller
//   Interrupt requester for the monocycle CPU. It latches rising-edge requests
//   from N_SRC sources and picks a winner by fixed priority (source 0 is the
//   highest). The winner's jump vector is offered through a req/ack/ret
//   handshake. The CPU pushes and pops the PC itself.
//
//   Handshake: int_req stays high in REQ. int_id and int_vec are frozen while
//   it is high. The first cycle with int_ack=1 takes the request, and the block
//   moves to SERVICE (int_act=1). It stays there until int_ret=1. If int_en
//   drops before an ack, the offer is withdrawn and the request stays pending.
//   An ack in that same cycle still takes the request. int_ack outside REQ and
//   int_ret outside SERVICE have no effect.
//
//   Ports:
//     clk, reset  system clock, synchronous active-high reset
//     irq_src     peripheral request lines (rising edge = request)
//     int_en      CPU global interrupt enable
//     mask_we     mask write strobe; mask_wd is the new mask (1 = enabled)
//     int_ack     CPU took the vector
//     int_ret     CPU executed return-from-interrupt
//     int_req     request to the CPU
//     int_vec     jump address; valid while int_req=1
//     int_id      source being offered or serviced
//     int_act     a service routine is running
//     ovf         sticky per-source overflow flags
//     dbg_state   current FSM state (cpu_int_pkg encoding)
module int_controller
   import cpu_int_pkg::*;
#(
   parameter int                 N_SRC      = 4,
   parameter logic [VEC_W-1:0]   VEC_BASE   = VEC_BASE_DEF,
   parameter logic [VEC_W-1:0]   VEC_STRIDE = VEC_STRIDE_DEF,
   parameter logic [N_SRC-1:0]   MASK_RST   = {N_SRC{1'b1}}
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_SRC-1:0]    irq_src,
   input  logic                int_en,
   input  logic                mask_we,
   input  logic [N_SRC-1:0]    mask_wd,
   input  logic                int_ack,
   input  logic                int_ret,
   output logic                int_req,
   output logic [VEC_W-1:0]    int_vec,
   output logic [INT_ID_W-1:0] int_id,
   output logic                int_act,
   output logic [N_SRC-1:0]    ovf,
   output logic [1:0]          dbg_state
);

   logic [N_SRC-1:0]    mask_q, mask_d;
   int_state_t          state_q, state_d;
   logic [INT_ID_W-1:0] id_q, id_d;
   logic [VEC_W-1:0]    vec_q, vec_d;

   logic [N_SRC-1:0]    pend_w;
   logic [N_SRC-1:0]    clr_w;
   logic [N_SRC-1:0]    eligible_w;
   logic [INT_ID_W-1:0] win_id_w;
   logic                take_w;

   // Per-source edge capture
   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      int_edge_latch u_latch (
         .clk    (clk),
         .reset  (reset),
         .irq_i  (irq_src[g]),
         .clr_i  (clr_w[g]),
         .pend_o (pend_w[g]),
         .ovf_o  (ovf[g])
      );
   end

   // Masked sources keep their pending bit. They are only left out of arbitration.
   assign eligible_w = pend_w & mask_q;

   // Priority encoder. The loop runs downward, so the lowest set index wins.
   always_comb begin
      win_id_w = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible_w[i]) win_id_w = INT_ID_W'(i);
      end
   end

   always_comb begin
      mask_d = mask_we ? mask_wd : mask_q;
   end

   // FSM
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      vec_d   = vec_q;
      take_w  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (int_en && (|eligible_w)) begin
               state_d = ST_REQ;
               id_d    = win_id_w;
               vec_d   = vec_addr(VEC_BASE, VEC_STRIDE, win_id_w);
            end
         end
         ST_REQ: begin
            // The ack is tested first, so it wins over int_en dropping in the same cycle.
            if (int_ack) begin
               state_d = ST_SERVICE;
               take_w  = 1'b1;
            end else if (!int_en) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (int_ret) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      clr_w = '0;
      for (int i = 0; i < N_SRC; i++) begin
         clr_w[i] = take_w && (id_q == INT_ID_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q  <= MASK_RST;
         state_q <= ST_IDLE;
         id_q    <= '0;
         vec_q   <= VEC_BASE;
      end else begin
         mask_q  <= mask_d;
         state_q <= state_d;
         id_q    <= id_d;
         vec_q   <= vec_d;
      end
   end

   assign int_req   = (state_q == ST_REQ);
   assign int_act   = (state_q == ST_SERVICE);
   assign int_id    = id_q;
   assign int_vec   = vec_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_int_controller.sv
module tb_int_controller;

   localparam int N = 4;
   localparam int BASE = 'h3C0;
   localparam int STRIDE = 16;

   // Reference model modes: no offer, offering, servicing
   localparam int M_IDLE = 0;
   localparam int M_OFFER = 1;
   localparam int M_SERVE = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic [N-1:0]  irq_src = '0;
   logic          int_en = 1'b0;
   logic          mask_we = 1'b0;
   logic [N-1:0]  mask_wd = '0;
   logic          int_ack = 1'b0;
   logic          int_ret = 1'b0;
   logic          int_req;
   logic [9:0]    int_vec;
   logic [2:0]    int_id;
   logic          int_act;
   logic [N-1:0]  ovf;
   logic [1:0]    dbg_state;

   int_controller dut (
      .clk       (clk),
      .reset     (reset),
      .irq_src   (irq_src),
      .int_en    (int_en),
      .mask_we   (mask_we),
      .mask_wd   (mask_wd),
      .int_ack   (int_ack),
      .int_ret   (int_ret),
      .int_req   (int_req),
      .int_vec   (int_vec),
      .int_id    (int_id),
      .int_act   (int_act),
      .ovf       (ovf),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_mode;
   int          m_id;
   bit [N-1:0]  m_pend, m_prev, m_ovf, m_mask;

   function automatic int first_set(input bit [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Applies the rules for one posedge, using the inputs present at that edge.
   task automatic model_edge();
      bit [N-1:0] edges, taken, elig;
      int win;
      if (reset) begin
         m_pend = '0; m_prev = '0; m_ovf = '0; m_mask = '1;
         m_mode = M_IDLE; m_id = 0;
         return;
      end
      edges = irq_src & ~m_prev;
      taken = '0;
      elig  = m_pend & m_mask;
      win   = first_set(elig);
      case (m_mode)
         M_IDLE:  if (int_en && win >= 0) begin m_mode = M_OFFER; m_id = win; end
         M_OFFER: if (int_ack) begin m_mode = M_SERVE; taken[m_id] = 1'b1; end
                  else if (!int_en) m_mode = M_IDLE;
         default: if (int_ret) m_mode = M_IDLE;
      endcase
      m_ovf  = m_ovf | (edges & m_pend & ~taken);
      m_pend = (m_pend & ~taken) | edges;
      m_prev = irq_src;
      if (mask_we) m_mask = mask_wd;
   endtask

   function automatic int exp_vec(input int id);
      return (BASE + id * STRIDE) % 1024;
   endfunction

   // One clock: model follows the edge, outputs are compared 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("int_req", int_req, m_mode == M_OFFER);
      check("int_act", int_act, m_mode == M_SERVE);
      check("ovf", ovf, m_ovf);
      check("state", dbg_state, m_mode);
      if (m_mode != M_IDLE) begin
         check("int_id", int_id, m_id);
         check("int_vec", int_vec, exp_vec(m_id));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic pulse(input logic [N-1:0] v);
      irq_src = v;
      step();
      irq_src = '0;
   endtask

   task automatic ack_cycle();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
   endtask

   task automatic ret_cycle();
      int_ret = 1'b1;
      step();
      int_ret = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [9:0] v;
      // Reset state
      do_reset();
      check("rst_req", int_req, 1'b0);
      check("rst_act", int_act, 1'b0);
      check("rst_id", int_id, 3'd0);
      v = 10'h3C0; check("rst_vec", int_vec, v);
      check("rst_ovf", ovf, 4'h0);

      // 1: single pulse on source 2, request two posedges later
      int_en = 1'b1;
      pulse(4'b0100);
      check("t1_req_early", int_req, 1'b0);
      step();
      check("t1_req", int_req, 1'b1);
      check("t1_id", int_id, 3'd2);
      v = 10'h3E0; check("t1_vec", int_vec, v);
      ack_cycle(); step(); ret_cycle(); step();

      // 2: two sources at once, priority then the other one
      pulse(4'b1010);
      step();
      check("t2_id_a", int_id, 3'd1);
      v = 10'h3D0; check("t2_vec_a", int_vec, v);
      ack_cycle(); step(); ret_cycle();
      check("t2_gap", int_req, 1'b0);
      step();
      check("t2_id_b", int_id, 3'd3);
      v = 10'h3F0; check("t2_vec_b", int_vec, v);

      // 3: withdraw by dropping int_en, then re-offer
      int_en = 1'b0;
      step();
      check("t3_drop", int_req, 1'b0);
      int_en = 1'b1;
      step();
      check("t3_reoffer", int_req, 1'b1);
      check("t3_id", int_id, 3'd3);
      ack_cycle(); ret_cycle(); step();

      // 4: masked source latches but does not request
      mask_we = 1'b1; mask_wd = 4'b1110; step(); mask_we = 1'b0;
      pulse(4'b0001); step(); step();
      check("t4_masked", int_req, 1'b0);
      mask_we = 1'b1; mask_wd = 4'hF; step(); mask_we = 1'b0;
      step();
      check("t4_req", int_req, 1'b1);
      v = 10'h3C0; check("t4_vec", int_vec, v);
      ack_cycle(); ret_cycle(); step();

      // 5a: double pulse before ack -> ovf, single service
      pulse(4'b0100); step();
      pulse(4'b0100); step();
      check("t5_ovf", ovf, 4'b0100);
      ack_cycle(); ret_cycle(); step(); step();
      check("t5_single", int_req, 1'b0);
      // 5b: edge in the ack cycle keeps pending, no ovf
      do_reset();
      pulse(4'b0100); step();
      irq_src = 4'b0100; int_ack = 1'b1; step(); irq_src = '0; int_ack = 1'b0;
      check("t5_no_ovf", ovf, 4'b0000);
      step(); ret_cycle(); step();
      check("t5_second", int_req, 1'b1);
      check("t5_second_id", int_id, 3'd2);

      // 6: reset during service, stray ret ignored
      pulse(4'b0010); pulse(4'b0010);
      ack_cycle();
      check("t6_in_service", int_act, 1'b1);
      do_reset();
      check("t6_act", int_act, 1'b0);
      check("t6_req", int_req, 1'b0);
      check("t6_ovf", ovf, 4'h0);
      ret_cycle(); step();
      check("t6_stray_ret", int_act, 1'b0);

      // Random phase against the model
      for (int c = 0; c < 3000; c++) begin
         irq_src = N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
         int_en  = ($urandom_range(0, 9) != 0);
         int_ack = ($urandom_range(0, 2) == 0);
         int_ret = ($urandom_range(0, 3) == 0);
         mask_we = ($urandom_range(0, 19) == 0);
         mask_wd = N'($urandom_range(0, 15));
         reset   = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
